// File: rtl/mmcm_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmcm_ctrl_pkg                                                         |
// | State encoding, error codes and DRP merge helper for the MMCM ctrl.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mmcm_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    HOLD      = 4'd1,
    RD        = 4'd2,
    RD_WAIT   = 4'd3,
    WR        = 4'd4,
    WR_WAIT   = 4'd5,
    REL       = 4'd6,
    LOCK_WAIT = 4'd7,
    DONE      = 4'd8
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_RD_TO   = 2'd1;
  localparam logic [1:0] ERR_WR_TO   = 2'd2;
  localparam logic [1:0] ERR_LOCK_TO = 2'd3;

  // Mask bit 1 takes the new data bit, 0 keeps the bit read from the MMCM.
  function automatic logic [15:0] drp_merge(input logic [15:0] rd,
                                            input logic [15:0] mask,
                                            input logic [15:0] data);
    return (rd & ~mask) | (data & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmcm_drp_reconfig_ctrl_sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff                                                              |
// | Single-bit two-flop synchroniser, async active-low reset to 0.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmcm_drp_reconfig_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmcm_drp_reconfig_ctrl                                                |
// | One DRP read-modify-write per request, MMCM held in reset meanwhile,  |
// | then waits for re-lock. Sole driver of the MMCM DRP port and RST.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mmcm_drp_reconfig_ctrl
  import mmcm_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 8,
  parameter int DRP_TIMEOUT     = 64,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int CNT_W           = 16
) (
  input  logic        DCLK,
  input  logic        RST_N,
  input  logic        CFG_REQ,
  input  logic [6:0]  CFG_ADDR,
  input  logic [15:0] CFG_MASK,
  input  logic [15:0] CFG_DATA,
  output logic        CFG_BUSY,
  output logic        CFG_DONE,
  output logic [1:0]  CFG_ERR,
  output logic [15:0] CFG_RDATA,
  output logic        MMCM_RST,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  input  logic        LOCKED,
  output logic        LOCKED_SYNC
);

  // Last counter value of each phase. DRP waits start counting the cycle
  // after DEN, so the DONE pulse lands exactly DRP_TIMEOUT cycles after DEN.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRP_LAST  = CNT_W'(DRP_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [6:0]       addr_q;
  logic [15:0]      mask_q;
  logic [15:0]      data_q;
  logic [15:0]      rdata_q;
  logic             fin;
  logic [1:0]       fin_err;

  sync_2ff u_locked_sync (
    .clk   (DCLK),
    .rst_n (RST_N),
    .d     (LOCKED),
    .q     (LOCKED_SYNC)
  );

  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  // Terminal conditions of the wait states; DRDY wins over a same-cycle timeout.
  always_comb begin
    fin     = 1'b0;
    fin_err = ERR_OK;
    case (state)
      RD_WAIT: begin
        if (!DRDY && cnt >= DRP_LAST) begin
          fin     = 1'b1;
          fin_err = ERR_RD_TO;
        end
      end
      WR_WAIT: begin
        if (!DRDY && cnt >= DRP_LAST) begin
          fin     = 1'b1;
          fin_err = ERR_WR_TO;
        end
      end
      LOCK_WAIT: begin
        if (LOCKED_SYNC) begin
          fin = 1'b1;
        end else if (cnt >= LOCK_LAST) begin
          fin     = 1'b1;
          fin_err = ERR_LOCK_TO;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      CFG_BUSY  <= 1'b0;
      CFG_DONE  <= 1'b0;
      CFG_ERR   <= ERR_OK;
      CFG_RDATA <= '0;
      MMCM_RST  <= 1'b0;
      DADDR     <= '0;
      DEN       <= 1'b0;
      DWE       <= 1'b0;
      DI        <= '0;
    end else if (fin) begin
      // Every exit releases MMCM reset so the MMCM is never left held.
      CFG_DONE  <= 1'b1;
      CFG_ERR   <= fin_err;
      CFG_RDATA <= rdata_q;
      MMCM_RST  <= 1'b0;
      state     <= DONE;
    end else begin
      case (state)
        IDLE: begin
          if (CFG_REQ) begin
            addr_q   <= CFG_ADDR;
            mask_q   <= CFG_MASK;
            data_q   <= CFG_DATA;
            rdata_q  <= '0;
            cnt      <= '0;
            MMCM_RST <= 1'b1;
            CFG_BUSY <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (cnt >= HOLD_LAST) begin
            cnt   <= '0;
            DADDR <= addr_q;
            DEN   <= 1'b1;
            DWE   <= 1'b0;
            state <= RD;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RD: begin
          DEN   <= 1'b0;
          cnt   <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (DRDY) begin
            rdata_q <= DO;
            DI      <= drp_merge(DO, mask_q, data_q);
            DEN     <= 1'b1;
            DWE     <= 1'b1;
            state   <= WR;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WR: begin
          DEN   <= 1'b0;
          DWE   <= 1'b0;
          cnt   <= '0;
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (DRDY) begin
            MMCM_RST <= 1'b0;
            cnt      <= '0;
            state    <= REL;
          end else begin
            cnt <= cnt_inc;
          end
        end
        REL: begin
          cnt   <= '0;
          state <= LOCK_WAIT;
        end
        LOCK_WAIT: begin
          cnt <= cnt_inc;
        end
        DONE: begin
          CFG_DONE <= 1'b0;
          CFG_BUSY <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
